// File: rtl/contador_pkg.sv
// Shared constants for the up/down modulo counter family.
package contador_pkg;

    // Direction encoding on the Up input
    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // Boundary mode encoding on the Sat input
    localparam logic WRAP = 1'b0;
    localparam logic SAT  = 1'b1;

endpackage : contador_pkg

// File: rtl/contador_prescaler.sv
// Enable prescaler: emits one step per PRESCALE enabled falling edges.
module contador_prescaler #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic NEclk,
    input  logic Nreset,
    input  logic Enable,
    input  logic Clear,
    output logic step
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_d;
    logic          at_last;

    assign at_last = (presc == LAST);
    assign step    = Enable & at_last;

    // Next prescaler value: clear wins, otherwise advance on enabled edges
    always_comb begin
        presc_d = presc;
        if (!Nreset || Clear) begin
            presc_d = '0;
        end else if (Enable) begin
            presc_d = at_last ? '0 : presc + PW'(1);
        end
    end

    // Prescaler register, falling-edge clocked
    always_ff @(negedge NEclk) begin
        presc <= presc_d;
    end

endmodule : contador_prescaler

// File: rtl/contador_updown_mod.sv
// Up/down modulo-N counter with prescaler, load, wrap/saturate mode, cascade tc and sticky ovf.
module contador_updown_mod
    import contador_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned MODULO   = 10,
    parameter int unsigned PRESCALE = 1
) (
    input  logic            NEclk,
    input  logic            Nreset,
    input  logic            Enable,
    input  logic            Up,
    input  logic            Sat,
    input  logic            Load,
    input  logic [BITS-1:0] LoadVal,
    input  logic            ClearOvf,
    output logic [BITS-1:0] count,
    output logic            tc,
    output logic            wrap,
    output logic            ovf
);

    localparam logic [BITS-1:0] MAX_CNT = BITS'(MODULO - 1);

    // Reject illegal parameter combinations at elaboration
    if ((MODULO < 2) || (64'(MODULO) > (64'd1 << BITS)) || (PRESCALE < 1)) begin : g_param_check
        $fatal(1, "contador_updown_mod: illegal MODULO/PRESCALE");
    end

    logic            step;
    logic            at_bnd;
    logic            bnd_step;
    logic [BITS-1:0] count_d;
    logic            wrap_d;
    logic            ovf_d;

    contador_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .NEclk  (NEclk),
        .Nreset (Nreset),
        .Enable (Enable),
        .Clear  (Load),
        .step   (step)
    );

    // Boundary depends only on current direction; a boundary step sets ovf
    assign at_bnd   = (Up == UP) ? (count == MAX_CNT) : (count == '0);
    assign bnd_step = step & at_bnd & ~Load;
    assign tc       = bnd_step & Nreset;

    // Next count / wrap / ovf: reset > load > counting, ovf clear independent
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        ovf_d   = ovf;

        if (bnd_step) begin
            ovf_d = 1'b1;
        end else if (ClearOvf) begin
            ovf_d = 1'b0;
        end

        if (!Nreset) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (Load) begin
            count_d = (LoadVal > MAX_CNT) ? MAX_CNT : LoadVal;
        end else if (step) begin
            if (at_bnd) begin
                if (Sat == WRAP) begin
                    count_d = (Up == UP) ? '0 : MAX_CNT;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = (Up == UP) ? count + BITS'(1) : count - BITS'(1);
            end
        end
    end

    // State registers, falling-edge clocked
    always_ff @(negedge NEclk) begin
        count <= count_d;
        wrap  <= wrap_d;
        ovf   <= ovf_d;
    end

endmodule : contador_updown_mod

// File: tb/tb_contador_updown_mod.sv
// Directed bench for contador_updown_mod: table vectors plus prescale and cascade sequences.
module tb_contador_updown_mod;
    import contador_pkg::*;

    logic       NEclk;
    logic       rst, en, up, sat, ld, clr;
    logic [3:0] ldv;

    logic [3:0] cnt_lo, cnt_hi, cnt_p;
    logic       tc_lo, tc_hi, tc_p;
    logic       wrap_lo, wrap_hi, wrap_p;
    logic       ovf_lo, ovf_hi, ovf_p;

    int checks = 0;
    int errors = 0;

    // Low stage, also the main device under test (PRESCALE=1)
    contador_updown_mod #(.BITS(4), .MODULO(10), .PRESCALE(1)) dut (
        .NEclk(NEclk), .Nreset(rst), .Enable(en), .Up(up), .Sat(sat), .Load(ld),
        .LoadVal(ldv), .ClearOvf(clr), .count(cnt_lo), .tc(tc_lo), .wrap(wrap_lo), .ovf(ovf_lo));

    // High cascade stage fed by the low stage's tc
    contador_updown_mod #(.BITS(4), .MODULO(10), .PRESCALE(1)) dut_hi (
        .NEclk(NEclk), .Nreset(rst), .Enable(tc_lo), .Up(up), .Sat(sat), .Load(ld),
        .LoadVal(ldv), .ClearOvf(clr), .count(cnt_hi), .tc(tc_hi), .wrap(wrap_hi), .ovf(ovf_hi));

    // Prescaled instance
    contador_updown_mod #(.BITS(4), .MODULO(10), .PRESCALE(3)) dut_p (
        .NEclk(NEclk), .Nreset(rst), .Enable(en), .Up(up), .Sat(sat), .Load(ld),
        .LoadVal(ldv), .ClearOvf(clr), .count(cnt_p), .tc(tc_p), .wrap(wrap_p), .ovf(ovf_p));

    initial NEclk = 1'b1;
    always #5 NEclk = ~NEclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic       rst, en, up, sat, ld;
        logic [3:0] ldv;
        logic       clr;
        logic       tc;
        logic [3:0] cnt;
        logic       wrap, ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic r, input logic e, input logic u,
                                input logic s, input logic l, input logic [3:0] lv, input logic c,
                                input logic t, input logic [3:0] k, input logic w, input logic o);
        vec_t x;
        x.name = n; x.rst = r; x.en = e; x.up = u; x.sat = s; x.ld = l; x.ldv = lv; x.clr = c;
        x.tc = t; x.cnt = k; x.wrap = w; x.ovf = o;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d", name, act, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic u, input logic s,
                         input logic l, input logic [3:0] lv, input logic c);
        rst = r; en = e; up = u; sat = s; ld = l; ldv = lv; clr = c;
    endtask

    task automatic tick();
        @(negedge NEclk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, UP, WRAP, 1'b0, 4'd0, 1'b0);

        // name            rst en  up    sat   ld  ldv  clr  tc  cnt wrap ovf
        vecs.push_back(mk("reset",     0, 1, UP,   WRAP, 1, 5,  0,  0, 0, 0, 0));
        vecs.push_back(mk("hold",      1, 0, UP,   WRAP, 0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("up1",       1, 1, UP,   WRAP, 0, 0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("up2",       1, 1, UP,   WRAP, 0, 0,  0,  0, 2, 0, 0));
        vecs.push_back(mk("up3",       1, 1, UP,   WRAP, 0, 0,  0,  0, 3, 0, 0));
        vecs.push_back(mk("up4",       1, 1, UP,   WRAP, 0, 0,  0,  0, 4, 0, 0));
        vecs.push_back(mk("up5",       1, 1, UP,   WRAP, 0, 0,  0,  0, 5, 0, 0));
        vecs.push_back(mk("up6",       1, 1, UP,   WRAP, 0, 0,  0,  0, 6, 0, 0));
        vecs.push_back(mk("up7",       1, 1, UP,   WRAP, 0, 0,  0,  0, 7, 0, 0));
        vecs.push_back(mk("up8",       1, 1, UP,   WRAP, 0, 0,  0,  0, 8, 0, 0));
        vecs.push_back(mk("up9",       1, 1, UP,   WRAP, 0, 0,  0,  0, 9, 0, 0));
        vecs.push_back(mk("up_wrap",   1, 1, UP,   WRAP, 0, 0,  0,  1, 0, 1, 1));
        vecs.push_back(mk("up_after1", 1, 1, UP,   WRAP, 0, 0,  0,  0, 1, 0, 1));
        vecs.push_back(mk("up_after2", 1, 1, UP,   WRAP, 0, 0,  0,  0, 2, 0, 1));
        vecs.push_back(mk("ld2_clr",   1, 0, UP,   WRAP, 1, 2,  1,  0, 2, 0, 0));
        vecs.push_back(mk("dn_sat1",   1, 1, DOWN, SAT,  0, 0,  0,  0, 1, 0, 0));
        vecs.push_back(mk("dn_sat2",   1, 1, DOWN, SAT,  0, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("dn_sat3",   1, 1, DOWN, SAT,  0, 0,  0,  1, 0, 0, 1));
        vecs.push_back(mk("dn_sat4",   1, 1, DOWN, SAT,  0, 0,  0,  1, 0, 0, 1));
        vecs.push_back(mk("clr_ovf",   1, 0, DOWN, SAT,  0, 0,  1,  0, 0, 0, 0));
        vecs.push_back(mk("ld13",      1, 1, UP,   WRAP, 1, 13, 0,  0, 9, 0, 0));
        vecs.push_back(mk("ld5_at9",   1, 1, UP,   WRAP, 1, 5,  0,  0, 5, 0, 0));
        vecs.push_back(mk("ld10",      1, 0, UP,   WRAP, 1, 10, 0,  0, 9, 0, 0));
        vecs.push_back(mk("ld0",       1, 0, UP,   WRAP, 1, 0,  0,  0, 0, 0, 0));
        vecs.push_back(mk("dn_wrap",   1, 1, DOWN, WRAP, 0, 0,  0,  1, 9, 1, 1));
        vecs.push_back(mk("dir_up",    1, 1, UP,   WRAP, 0, 0,  0,  1, 0, 1, 1));
        vecs.push_back(mk("idle",      1, 0, UP,   WRAP, 0, 0,  0,  0, 0, 0, 1));
        vecs.push_back(mk("clr_cnt",   1, 1, UP,   WRAP, 0, 0,  1,  0, 1, 0, 0));
        vecs.push_back(mk("ld9",       1, 0, UP,   WRAP, 1, 9,  0,  0, 9, 0, 0));
        vecs.push_back(mk("set_clr",   1, 1, UP,   WRAP, 0, 0,  1,  1, 0, 1, 1));
        vecs.push_back(mk("ld9b",      1, 0, UP,   WRAP, 1, 9,  0,  0, 9, 0, 1));
        vecs.push_back(mk("sat_up",    1, 1, UP,   SAT,  0, 0,  0,  1, 9, 0, 1));
        vecs.push_back(mk("ld_no_tc",  1, 1, UP,   WRAP, 1, 3,  0,  0, 3, 0, 1));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].sat, vecs[i].ld, vecs[i].ldv, vecs[i].clr);
            #1;
            check({vecs[i].name, ".tc"}, 32'(tc_lo), 32'(vecs[i].tc));
            tick();
            check({vecs[i].name, ".count"}, 32'(cnt_lo), 32'(vecs[i].cnt));
            check({vecs[i].name, ".wrap"}, 32'(wrap_lo), 32'(vecs[i].wrap));
            check({vecs[i].name, ".ovf"}, 32'(ovf_lo), 32'(vecs[i].ovf));
        end

        // Reset is synchronous: asserting it between edges changes nothing until the edge
        drive(1'b0, 1'b1, UP, WRAP, 1'b0, 4'd0, 1'b0);
        #2;
        check("sync_rst.between", 32'(cnt_lo), 32'd3);
        check("sync_rst.ovf_between", 32'(ovf_lo), 32'd1);
        tick();
        check("sync_rst.count", 32'(cnt_lo), 32'd0);
        check("sync_rst.ovf", 32'(ovf_lo), 32'd0);
        check("sync_rst.p_count", 32'(cnt_p), 32'd0);

        // Prescale by 3: steps on every third enabled edge, Enable=0 holds the prescaler
        begin
            logic [6:0] en_pat;
            logic [3:0] exp_p [7];
            en_pat = 7'b1111011;
            exp_p = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2};
            for (int k = 0; k < 7; k++) begin
                drive(1'b1, en_pat[k], UP, WRAP, 1'b0, 4'd0, 1'b0);
                tick();
                check($sformatf("presc.e%0d", k), 32'(cnt_p), 32'(exp_p[k]));
            end
        end
        drive(1'b1, 1'b1, UP, WRAP, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        check("presc.mid", 32'(cnt_p), 32'd2);
        // Load mid-prescale restarts the prescaler
        drive(1'b1, 1'b1, UP, WRAP, 1'b1, 4'd9, 1'b0);
        #1;
        check("presc.ld_tc", 32'(tc_p), 32'd0);
        tick();
        check("presc.ld_count", 32'(cnt_p), 32'd9);
        drive(1'b1, 1'b1, UP, WRAP, 1'b0, 4'd0, 1'b0);
        #1;
        check("presc.r1_tc", 32'(tc_p), 32'd0);
        tick();
        check("presc.r1_count", 32'(cnt_p), 32'd9);
        #1;
        check("presc.r2_tc", 32'(tc_p), 32'd0);
        tick();
        check("presc.r2_count", 32'(cnt_p), 32'd9);
        #1;
        check("presc.r3_tc", 32'(tc_p), 32'd1);
        tick();
        check("presc.r3_count", 32'(cnt_p), 32'd0);
        check("presc.r3_wrap", 32'(wrap_p), 32'd1);
        check("presc.r3_ovf", 32'(ovf_p), 32'd1);

        // Two-stage cascade: low tc enables the high stage
        drive(1'b0, 1'b0, UP, WRAP, 1'b0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 1'b1, UP, WRAP, 1'b0, 4'd0, 1'b0);
        for (int k = 0; k < 25; k++) tick();
        check("casc25.lo", 32'(cnt_lo), 32'd5);
        check("casc25.hi", 32'(cnt_hi), 32'd2);
        for (int k = 0; k < 4; k++) tick();
        check("casc29.lo", 32'(cnt_lo), 32'd9);
        check("casc29.tc_lo", 32'(tc_lo), 32'd1);
        check("casc29.tc_hi", 32'(tc_hi), 32'd0);
        drive(1'b1, 1'b0, UP, WRAP, 1'b0, 4'd0, 1'b1);
        #1;
        check("casc.idle_tc_lo", 32'(tc_lo), 32'd0);
        tick();
        check("casc.clr_ovf", 32'(ovf_lo), 32'd0);
        check("casc.hold_lo", 32'(cnt_lo), 32'd9);
        drive(1'b1, 1'b1, UP, WRAP, 1'b0, 4'd0, 1'b1);
        tick();
        check("casc.set_wins", 32'(ovf_lo), 32'd1);
        check("casc.lo_wrap", 32'(wrap_lo), 32'd1);
        check("casc.lo", 32'(cnt_lo), 32'd0);
        check("casc.hi", 32'(cnt_hi), 32'd3);
        check("casc.hi_ovf", 32'(ovf_hi), 32'd0);
        check("casc.hi_wrap", 32'(wrap_hi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_contador_updown_mod
